capture_occupancy_counter: RTL
==============================

// Module: capture_occupancy_counter
// PURPOSE
//   Parametrised up/down occupancy counter for capture events. It replaces the fixed
//   3-bit, full-at-6 capture counter. Counts capture (+1) and drain (-1) pulses and
//   flags empty, almost_full and full, with sticky overflow/underflow error flags.
//   Sits between a capture source and its buffer/consumer as the flow-control tracker.
// PARAMETERS
//   DEPTH        6          capacity; full asserted when count == DEPTH (DEPTH >= 2)
//   ALMOST_FULL  DEPTH-1    almost_full threshold, 1 <= ALMOST_FULL <= DEPTH
//   CW           clog2(DEPTH+1)  count width; derived, not overridden
// PORTS
//   clock        in   1    single clock, all state updates on rising edge
//   rst          in   1    synchronous reset, active-high
//   clear        in   1    synchronous soft clear of count and sticky flags
//   capture      in   1    one-cycle increment request
//   drain        in   1    one-cycle decrement request
//   count        out  CW   current occupancy
//   empty        out  1    count == 0
//   almost_full  out  1    count >= ALMOST_FULL
//   full         out  1    count == DEPTH
//   overflow     out  1    sticky: capture attempted while full without drain
//   underflow    out  1    sticky: drain attempted while empty without capture
// BEHAVIOUR
//   - Clock is `clock`. Reset is synchronous and active-high on `rst`.
//   - Reset (rst=1 at edge): count=0, empty=1, almost_full=0, full=0, overflow=0, underflow=0.
//   - Priority per edge: rst > clear > capture/drain. Clear gives the reset values.
//   - Control FSM on count: S_EMPTY (0), S_PART (1..DEPTH-1), S_FULL (DEPTH).
//     Transitions occur only through legal +1/-1 steps. There is no wrap-around.
//   - Update table. Values are shown for the next cycle.
//       cap=0 drn=0 : hold
//       cap=1 drn=1 : hold in every state. This is legal even when full or empty; no error flag.
//       cap=1 drn=0 : S_FULL -> hold, overflow<=1; otherwise count+1
//       cap=0 drn=1 : S_EMPTY -> hold, underflow<=1; otherwise count-1
//   - Saturating: count never exceeds DEPTH and never goes below 0.
//   - Latency: count and all flags reflect a request on the edge after it is sampled.
//     Flags are decoded combinationally from the count register, so they are always
//     consistent with count.
//   - Sticky flags clear only by rst or clear. A clear in the same cycle as an
//     illegal request wins, so the flag stays 0.
//   - Reset mid-operation discards the count. No partial state survives.
//   - All arithmetic is CW-bit unsigned. Comparisons to DEPTH and ALMOST_FULL use CW-bit constants.
// CONFIGURATION
//   CAPTURE_CNT_PEAK_EN defined:
//     - Adds output `peak [CW]`, a high-water mark of count.
//     - peak <= count_next when count_next > peak.
//     - peak resets to 0 on rst or clear.
//   CAPTURE_CNT_PEAK_EN undefined: the port and the register are absent.
//     All other behaviour is identical.
// STRUCTURE
//   - Package capture_cnt_pkg holds:
//       - FSM state encoding (S_EMPTY=2'd0, S_PART=2'd1, S_FULL=2'd2);
//       - a clog2 constant function;
//       - the update-action encoding (HOLD/INC/DEC/ERR_OVF/ERR_UDF).
//   - One sub-module, occ_flag_decode: pure combinational count -> empty/almost_full/full/state.
//     It is parametrised on DEPTH and ALMOST_FULL.
//   - The top level holds the count register, sticky flags, optional peak, and the update table.
// TESTING  (DEPTH=6, ALMOST_FULL=5)
//   - rst=1 for 2 cycles with capture=1 -> count=0, empty=1, full=0, both error flags 0.
//   - 6 capture pulses -> count 1..6 on successive cycles; almost_full rises at count=5;
//     full=1 at count=6. A 7th capture -> count holds at 6, overflow=1.
//   - From full: capture=drain=1 -> count stays 6, overflow stays 0.
//     Then 6 drains -> empty=1. A 7th drain -> count 0, underflow=1.
//   - count=3, overflow=1, then clear=1 with capture=1 -> count=0, overflow=0.
//   - count=4, then rst=1 mid-sequence with drain=1 -> next cycle count=0, all flags at reset values.
//   - With CAPTURE_CNT_PEAK_EN: rise to 5, fall to 2 -> peak=5. After clear -> peak=0.

Source files
------------

// File: rtl/capture_occupancy_counter_pkg.sv
// Shared types for the capture occupancy counter: FSM states, update actions, clog2.
// Optional high-water mark output is enabled with CAPTURE_CNT_PEAK_EN.
package capture_cnt_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } occ_state_e;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    INC     = 3'd1,
    DEC     = 3'd2,
    ERR_OVF = 3'd3,
    ERR_UDF = 3'd4
  } occ_action_e;

  // Ceiling log2; callers pass DEPTH+1 so the result covers 0..DEPTH inclusive.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/capture_occupancy_counter_if.sv
// Request/status bundle between a capture source and the occupancy counter.
// The peak signal exists only when CAPTURE_CNT_PEAK_EN is defined.
interface capture_occupancy_counter_if
  import capture_cnt_pkg::*;
#(
  parameter int unsigned DEPTH = 6
);
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic          clear;
  logic          capture;
  logic          drain;
  logic [CW-1:0] count;
  logic          empty;
  logic          almost_full;
  logic          full;
  logic          overflow;
  logic          underflow;
`ifdef CAPTURE_CNT_PEAK_EN
  logic [CW-1:0] peak;
`endif

  modport master (
    output clear, capture, drain,
`ifdef CAPTURE_CNT_PEAK_EN
    input  peak,
`endif
    input  count, empty, almost_full, full, overflow, underflow
  );

  modport slave (
    input  clear, capture, drain,
`ifdef CAPTURE_CNT_PEAK_EN
    output peak,
`endif
    output count, empty, almost_full, full, overflow, underflow
  );

endinterface

// File: rtl/capture_occupancy_counter_flag_decode.sv
// Pure combinational decode of the occupancy count into flags and FSM state.
module occ_flag_decode
  import capture_cnt_pkg::*;
#(
  parameter  int unsigned DEPTH       = 6,
  parameter  int unsigned ALMOST_FULL = DEPTH - 1,
  localparam int unsigned CW          = clog2(DEPTH + 1)
) (
  input  logic [CW-1:0] count,
  output logic          empty_c,
  output logic          almost_full_c,
  output logic          full_c,
  output occ_state_e    state_c
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);

  always_comb begin
    empty_c       = (count == '0);
    almost_full_c = (count >= AF_C);
    full_c        = (count == DEPTH_C);
    state_c       = S_PART;
    if (empty_c) begin
      state_c = S_EMPTY;
    end else if (full_c) begin
      state_c = S_FULL;
    end
  end

endmodule

// File: rtl/capture_occupancy_counter.sv
// Saturating up/down occupancy counter with sticky overflow/underflow flags.
// Define CAPTURE_CNT_PEAK_EN to add a high-water mark register on bus.peak.
module capture_occupancy_counter
  import capture_cnt_pkg::*;
#(
  parameter int unsigned DEPTH       = 6,
  parameter int unsigned ALMOST_FULL = DEPTH - 1
) (
  input logic                        clock,
  input logic                        rst,
  capture_occupancy_counter_if.slave bus
);

  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          empty_c, almost_full_c, full_c;
  occ_state_e    state_c;
  occ_action_e   action_c;

  occ_flag_decode #(
    .DEPTH       (DEPTH),
    .ALMOST_FULL (ALMOST_FULL)
  ) u_decode (
    .count         (count_q),
    .empty_c       (empty_c),
    .almost_full_c (almost_full_c),
    .full_c        (full_c),
    .state_c       (state_c)
  );

  // Update table: simultaneous capture and drain always holds without error.
  always_comb begin
    action_c    = HOLD;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (bus.capture && !bus.drain) begin
      action_c = (state_c == S_FULL) ? ERR_OVF : INC;
    end else if (bus.drain && !bus.capture) begin
      action_c = (state_c == S_EMPTY) ? ERR_UDF : DEC;
    end

    case (action_c)
      INC:     count_d     = count_q + CW'(1);
      DEC:     count_d     = count_q - CW'(1);
      ERR_OVF: overflow_d  = 1'b1;
      ERR_UDF: underflow_d = 1'b1;
      default: count_d     = count_q;
    endcase

    if (bus.clear) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef CAPTURE_CNT_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  // High-water mark tracks the value count is about to take.
  always_comb begin
    peak_d = peak_q;
    if (bus.clear) begin
      peak_d = '0;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign bus.peak = peak_q;
`endif

  assign bus.count       = count_q;
  assign bus.empty       = empty_c;
  assign bus.almost_full = almost_full_c;
  assign bus.full        = full_c;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule
